button_code_tx: RTL

Keypad front end that turns 16 raw, bouncy pushbutton inputs into the single-cycle 10-bit `button` code consumed by `math_calculator_fsm`. It sits between the board pins and the calculator FSM. Per key, it synchronises and debounces the input. It emits exactly one code pulse per debounced press, arbitrates between simultaneous keys, and requires all keys to be released before the next emission. The only exception is a Clear override.

---
 rtl/button_code_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/button_code_tx.sv
// Keypad front end: synchronises and debounces 16 raw keys and emits one calculator
// key code pulse per debounced press, with priority arbitration and a clear override.
module button_code_tx #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_raw,
  output logic [9:0]  button,
  output logic        key_valid,
  output logic [3:0]  key_index,
  output logic        multi_press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StWaitRelease
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     sync1_q, sync2_q, stable_q;
  logic [CntW-1:0] cnt_q [16];
  logic            clear_prev_q;

  logic [9:0]      button_q, button_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_index_q, key_index_d;
  logic            multi_q, multi_d;

  logic [3:0]      sel_idx;
  logic            multi_now;
  logic            clear_rise;

  function automatic logic [9:0] key_code(input logic [3:0] idx);
    logic [9:0] code;
    case (idx)
      4'd9:    code = 10'b10_0000_0000;
      4'd10:   code = 10'b10_0000_0001;
      4'd11:   code = 10'b10_0000_0010;
      4'd12:   code = 10'b10_0000_0100;
      4'd13:   code = 10'b10_0000_1000;
      4'd14:   code = 10'b11_0000_0000;
      4'd15:   code = 10'b11_1000_0000;
      default: code = 10'd1 << idx;
    endcase
    return code;
  endfunction

  // Per-key synchroniser and debounce counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      clear_prev_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= key_raw;
      sync2_q      <= sync1_q;
      clear_prev_q <= stable_q[15];
      for (int i = 0; i < 16; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          stable_q[i] <= ~stable_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Highest set index wins.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (stable_q[i]) begin
        sel_idx = 4'(i);
      end
    end
  end

  assign multi_now  = ($countones(stable_q) > 1);
  assign clear_rise = stable_q[15] & ~clear_prev_q;

  always_comb begin
    state_d     = state_q;
    button_d    = button_q;
    key_valid_d = key_valid_q;
    key_index_d = key_index_q;
    multi_d     = multi_q;
    case (state_q)
      StIdle: begin
        if (stable_q != '0) begin
          state_d     = StEmit;
          button_d    = key_code(sel_idx);
          key_index_d = sel_idx;
          key_valid_d = 1'b1;
          multi_d     = multi_now;
        end
      end
      StEmit: begin
        state_d     = StWaitRelease;
        button_d    = '0;
        key_valid_d = 1'b0;
        multi_d     = 1'b0;
      end
      StWaitRelease: begin
        if (stable_q == '0) begin
          state_d = StIdle;
        end else if (clear_rise && (key_index_q != 4'd15)) begin
          // Clear pre-empts whatever key is still held.
          state_d     = StEmit;
          button_d    = key_code(4'd15);
          key_index_d = 4'd15;
          key_valid_d = 1'b1;
          multi_d     = multi_now;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      button_q    <= '0;
      key_valid_q <= 1'b0;
      key_index_q <= '0;
      multi_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      button_q    <= button_d;
      key_valid_q <= key_valid_d;
      key_index_q <= key_index_d;
      multi_q     <= multi_d;
    end
  end

  assign button      = button_q;
  assign key_valid   = key_valid_q;
  assign key_index   = key_index_q;
  assign multi_press = multi_q;

endmodule
